// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the dms decoder:
// FSM encoding, next-PC source codes and the immediate-marker bit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH_IR  = 2'd1,
        ST_FETCH_IMM = 2'd2,
        ST_READY     = 2'd3
    } fetch_state_t;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BRC = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_RET = 2'd3;

    localparam int IMM_BIT_DEF = 15;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC source mux: sequential, conditional branch,
// jump to immediate, or return address from dms.
import fetch_unit_pkg::*;

module fetch_pc_sel (
    input  logic [1:0]  i_pc_sel,
    input  logic        i_cmp_result,
    input  logic [15:0] i_imr,
    input  logic [15:0] i_ra_in,
    input  logic [15:0] i_ra_out,
    output logic [15:0] o_target
);

    logic [15:0] w_target;

    always_comb begin
        w_target = i_ra_in;
        unique case (i_pc_sel)
            PC_SEQ: w_target = i_ra_in;
            PC_BRC: w_target = i_cmp_result ? i_imr : i_ra_in;
            PC_JMP: w_target = i_imr;
            PC_RET: w_target = i_ra_out;
        endcase
    end

    assign o_target = w_target;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads one- or two-word instructions
// and hands IR/ImR/RAIn to dms, then steers the PC on next.
import fetch_unit_pkg::*;

module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          IMM_BIT  = IMM_BIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_ready,
    input  logic        next,
    input  logic [1:0]  pc_sel,
    input  logic        cmp_result,
    input  logic [15:0] RAOut,
    output logic [15:0] IR,
    output logic [15:0] ImR,
    output logic [15:0] RAIn,
    output logic [15:0] pc,
    output logic        instr_valid
);

    fetch_state_t r_state;
    logic [15:0]  r_pc;
    logic [15:0]  r_addr;
    logic         r_rd;
    logic [15:0]  r_ir;
    logic [15:0]  r_imr;
    logic [15:0]  r_ra;
    logic         r_valid;

    logic [15:0]  w_target;
    logic [15:0]  w_pc_inc1;
    logic [15:0]  w_pc_inc2;

    assign w_pc_inc1 = r_pc + 16'd1;
    assign w_pc_inc2 = r_pc + 16'd2;

    fetch_pc_sel u_pc_sel (
        .i_pc_sel     (pc_sel),
        .i_cmp_result (cmp_result),
        .i_imr        (r_imr),
        .i_ra_in      (r_ra),
        .i_ra_out     (RAOut),
        .o_target     (w_target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_rd    <= 1'b0;
            r_ir    <= 16'h0000;
            r_imr   <= 16'h0000;
            r_ra    <= 16'h0000;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH_IR;
                    r_addr  <= r_pc;
                    r_rd    <= 1'b1;
                end
                ST_FETCH_IR: begin
                    if (mem_ready) begin
                        r_ir <= mem_data;
                        if (mem_data[IMM_BIT]) begin
                            r_state <= ST_FETCH_IMM;
                            r_addr  <= w_pc_inc1;
                        end else begin
                            r_state <= ST_READY;
                            r_ra    <= w_pc_inc1;
                            r_rd    <= 1'b0;
                            r_valid <= 1'b1;
                        end
                    end
                end
                ST_FETCH_IMM: begin
                    if (mem_ready) begin
                        r_imr   <= mem_data;
                        r_ra    <= w_pc_inc2;
                        r_rd    <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= ST_READY;
                    end
                end
                ST_READY: begin
                    // Sources are sampled only on this edge.
                    if (next) begin
                        r_pc    <= w_target;
                        r_addr  <= w_target;
                        r_valid <= 1'b0;
                        r_rd    <= 1'b1;
                        r_state <= ST_FETCH_IR;
                    end
                end
            endcase
        end
    end

    assign mem_addr    = r_addr;
    assign mem_rd      = r_rd;
    assign IR          = r_ir;
    assign ImR         = r_imr;
    assign RAIn        = r_ra;
    assign pc          = r_pc;
    assign instr_valid = r_valid;

endmodule
